// File: rtl/motor_portao_pkg.sv
// Shared definitions for the gate motor plant and its neighbours.
// State encodings, command codes and the command decoder.
package motor_portao_pkg;

    typedef enum logic [2:0] {
        ST_PARADO   = 3'd0,
        ST_ABRINDO  = 3'd1,
        ST_FECHANDO = 3'd2,
        ST_PAUSA    = 3'd3
    } estado_t;

    typedef enum logic [1:0] {
        CMD_STOP     = 2'd0,
        CMD_OPEN     = 2'd1,
        CMD_CLOSE    = 2'd2,
        CMD_CONFLICT = 2'd3
    } cmd_t;

    // {fechar, abrir} maps directly onto the command codes
    function automatic cmd_t decode_cmd(input logic abrir, input logic fechar);
        return cmd_t'({fechar, abrir});
    endfunction

endpackage

// File: rtl/motor_portao_divisor_passo.sv
// Position-step prescaler: one step pulse every DIV enabled cycles.
// Clear has priority and restarts the count from zero.
module motor_portao_divisor_passo #(
    parameter int DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_passo
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] W_TOP = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    // Count enabled cycles, wrapping at DIV-1
    always_ff @(posedge clock) begin
        if (reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (r_cnt == W_TOP) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_passo = i_en && (r_cnt == W_TOP);

endmodule

// File: rtl/motor_portao.sv
// Behavioural gate motor plant: tracks gate position from motor commands,
// drives limit switches, enforces reversal dead-time and flags conflicts.
module motor_portao
    import motor_portao_pkg::*;
#(
    parameter int CURSO    = 16,
    parameter int DIV      = 4,
    parameter int PAUSA    = 3,
    parameter int POS_W    = 5,
    parameter int POS_INIT = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             abrir,
    input  logic             fechar,
    output logic             trilhoAberto,
    output logic             trilhoFechado,
    output logic [POS_W-1:0] posicao,
    output logic             movendo,
    output logic             erro,
    output logic [2:0]       estado_motor
);

    localparam int PW = (PAUSA > 1) ? $clog2(PAUSA) : 1;
    localparam logic [POS_W-1:0] W_CURSO = POS_W'(CURSO);
    localparam logic [POS_W-1:0] W_INIT  = POS_W'(POS_INIT);
    localparam logic [PW-1:0]    W_PLAST = PW'(PAUSA - 1);

    estado_t          r_estado;
    logic [POS_W-1:0] r_posicao;
    logic [PW-1:0]    r_pausa_cnt;
    logic             r_erro;

    cmd_t    w_cmd;
    logic    w_seguir;
    logic    w_passo;
    logic    w_no_fim;
    logic    w_no_inicio;
    estado_t w_de_parado;

    assign w_cmd       = decode_cmd(abrir, fechar);
    assign w_no_fim    = (r_posicao == W_CURSO);
    assign w_no_inicio = (r_posicao == '0);

    // Motion continues only while the matching command is held
    assign w_seguir = ((r_estado == ST_ABRINDO) && (w_cmd == CMD_OPEN))
                   || ((r_estado == ST_FECHANDO) && (w_cmd == CMD_CLOSE));

    motor_portao_divisor_passo #(
        .DIV (DIV)
    ) u_divisor (
        .clock   (clock),
        .reset   (reset),
        .i_clr   (~w_seguir),
        .i_en    (w_seguir),
        .o_passo (w_passo)
    );

    // Next state when leaving rest (also used at the end of the dead-time)
    always_comb begin
        w_de_parado = ST_PARADO;
        if ((w_cmd == CMD_OPEN) && !w_no_fim) begin
            w_de_parado = ST_ABRINDO;
        end else if ((w_cmd == CMD_CLOSE) && !w_no_inicio) begin
            w_de_parado = ST_FECHANDO;
        end
    end

    // State, position, dead-time counter and conflict flag
    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado    <= ST_PARADO;
            r_posicao   <= W_INIT;
            r_pausa_cnt <= '0;
            r_erro      <= 1'b0;
        end else begin
            r_erro <= (w_cmd == CMD_CONFLICT);
            if (w_cmd == CMD_CONFLICT) begin
                r_estado    <= ST_PARADO;
                r_pausa_cnt <= '0;
            end else begin
                case (r_estado)
                    ST_PARADO: begin
                        r_estado <= w_de_parado;
                    end
                    ST_ABRINDO: begin
                        if (w_cmd == CMD_OPEN) begin
                            if (w_passo && !w_no_fim) begin
                                r_posicao <= r_posicao + POS_W'(1);
                                if (r_posicao == W_CURSO - POS_W'(1)) begin
                                    r_estado <= ST_PARADO;
                                end
                            end
                        end else if (w_cmd == CMD_CLOSE) begin
                            r_estado    <= ST_PAUSA;
                            r_pausa_cnt <= '0;
                        end else begin
                            r_estado <= ST_PARADO;
                        end
                    end
                    ST_FECHANDO: begin
                        if (w_cmd == CMD_CLOSE) begin
                            if (w_passo && !w_no_inicio) begin
                                r_posicao <= r_posicao - POS_W'(1);
                                if (r_posicao == POS_W'(1)) begin
                                    r_estado <= ST_PARADO;
                                end
                            end
                        end else if (w_cmd == CMD_OPEN) begin
                            r_estado    <= ST_PAUSA;
                            r_pausa_cnt <= '0;
                        end else begin
                            r_estado <= ST_PARADO;
                        end
                    end
                    ST_PAUSA: begin
                        if (r_pausa_cnt == W_PLAST) begin
                            r_pausa_cnt <= '0;
                            r_estado    <= w_de_parado;
                        end else begin
                            r_pausa_cnt <= r_pausa_cnt + PW'(1);
                        end
                    end
                    default: begin
                        r_estado    <= ST_PARADO;
                        r_pausa_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign trilhoAberto  = w_no_fim;
    assign trilhoFechado = w_no_inicio;
    assign posicao       = r_posicao;
    assign movendo       = (r_estado == ST_ABRINDO) || (r_estado == ST_FECHANDO);
    assign erro          = r_erro;
    assign estado_motor  = r_estado;

endmodule

// File: tb/tb_motor_portao.sv
// Directed bench for the gate motor plant with default parameters.
// Expected values are hand-derived edge counts from the command edge.
module tb_motor_portao;

    logic       clock = 1'b0;
    logic       reset;
    logic       abrir;
    logic       fechar;
    logic       trilhoAberto;
    logic       trilhoFechado;
    logic [4:0] posicao;
    logic       movendo;
    logic       erro;
    logic [2:0] estado_motor;

    int n_checks = 0;
    int n_errors = 0;

    motor_portao #(
        .CURSO    (16),
        .DIV      (4),
        .PAUSA    (3),
        .POS_W    (5),
        .POS_INIT (0)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .abrir         (abrir),
        .fechar        (fechar),
        .trilhoAberto  (trilhoAberto),
        .trilhoFechado (trilhoFechado),
        .posicao       (posicao),
        .movendo       (movendo),
        .erro          (erro),
        .estado_motor  (estado_motor)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        reset  = 1'b1;
        abrir  = 1'b0;
        fechar = 1'b0;
        tick(2);
        reset = 1'b0;

        // reset state
        chk("rst_pos", int'(posicao), 0);
        chk("rst_fechado", int'(trilhoFechado), 1);
        chk("rst_aberto", int'(trilhoAberto), 0);
        chk("rst_movendo", int'(movendo), 0);
        chk("rst_erro", int'(erro), 0);
        chk("rst_estado", int'(estado_motor), 0);
        tick(1);
        chk("idle_estado", int'(estado_motor), 0);

        // open to 7, then reverse
        abrir = 1'b1;
        tick(1);
        chk("op_estado", int'(estado_motor), 1);
        chk("op_movendo", int'(movendo), 1);
        tick(3);
        chk("op_pos_e4", int'(posicao), 0);
        tick(1);
        chk("op_pos_e5", int'(posicao), 1);
        chk("op_fechado", int'(trilhoFechado), 0);
        tick(24);
        chk("op_pos_e29", int'(posicao), 7);
        abrir  = 1'b0;
        fechar = 1'b1;
        tick(1);
        chk("rev_pausa1", int'(estado_motor), 3);
        chk("rev_pos1", int'(posicao), 7);
        chk("rev_movendo", int'(movendo), 0);
        tick(2);
        chk("rev_pausa3", int'(estado_motor), 3);
        chk("rev_pos3", int'(posicao), 7);
        tick(1);
        chk("rev_fech", int'(estado_motor), 2);
        tick(3);
        chk("rev_pos_e36", int'(posicao), 7);
        tick(1);
        chk("rev_pos_e37", int'(posicao), 6);
        tick(23);
        chk("cl_pos_e60", int'(posicao), 1);
        tick(1);
        chk("cl_pos_e61", int'(posicao), 0);
        chk("cl_fechado", int'(trilhoFechado), 1);
        chk("cl_estado", int'(estado_motor), 0);
        chk("cl_movendo", int'(movendo), 0);

        // close at 0: no motion
        tick(2);
        chk("sat0_estado", int'(estado_motor), 0);
        chk("sat0_pos", int'(posicao), 0);
        chk("sat0_erro", int'(erro), 0);

        // full travel open
        fechar = 1'b0;
        abrir  = 1'b1;
        tick(1);
        chk("full_estado", int'(estado_motor), 1);
        tick(4);
        chk("full_pos_e5", int'(posicao), 1);
        tick(59);
        chk("full_pos_e64", int'(posicao), 15);
        chk("full_aberto64", int'(trilhoAberto), 0);
        chk("full_mov64", int'(movendo), 1);
        tick(1);
        chk("full_pos_e65", int'(posicao), 16);
        chk("full_aberto65", int'(trilhoAberto), 1);
        chk("full_mov65", int'(movendo), 0);
        chk("full_est65", int'(estado_motor), 0);

        // open at CURSO: no motion
        tick(3);
        chk("sat16_estado", int'(estado_motor), 0);
        chk("sat16_pos", int'(posicao), 16);
        chk("sat16_erro", int'(erro), 0);

        // conflict while opening at 5
        reset = 1'b1;
        abrir = 1'b0;
        tick(1);
        reset = 1'b0;
        chk("rst2_pos", int'(posicao), 0);
        abrir = 1'b1;
        tick(21);
        chk("cf_pos5", int'(posicao), 5);
        chk("cf_est_pre", int'(estado_motor), 1);
        fechar = 1'b1;
        tick(1);
        chk("cf_estado", int'(estado_motor), 0);
        chk("cf_erro1", int'(erro), 1);
        chk("cf_pos", int'(posicao), 5);
        tick(1);
        chk("cf_erro2", int'(erro), 1);
        abrir  = 1'b0;
        fechar = 1'b0;
        tick(1);
        chk("cf_erro_rel", int'(erro), 0);
        chk("cf_pos_rel", int'(posicao), 5);

        // reset during closing at 9
        abrir = 1'b1;
        tick(17);
        chk("r6_pos9", int'(posicao), 9);
        abrir  = 1'b0;
        fechar = 1'b1;
        tick(1);
        chk("r6_pausa", int'(estado_motor), 3);
        tick(3);
        chk("r6_fech", int'(estado_motor), 2);
        tick(2);
        chk("r6_pos_hold", int'(posicao), 9);
        reset = 1'b1;
        tick(1);
        chk("r6_estado", int'(estado_motor), 0);
        chk("r6_pos", int'(posicao), 0);
        chk("r6_fechado", int'(trilhoFechado), 1);
        chk("r6_movendo", int'(movendo), 0);
        reset  = 1'b0;
        fechar = 1'b0;

        // stop discards partial step; prescaler restarts
        abrir = 1'b1;
        tick(3);
        chk("stp_estado", int'(estado_motor), 1);
        abrir = 1'b0;
        tick(1);
        chk("stp_parado", int'(estado_motor), 0);
        chk("stp_pos", int'(posicao), 0);
        abrir = 1'b1;
        tick(4);
        chk("stp_pos_e4", int'(posicao), 0);
        tick(1);
        chk("stp_pos_e5", int'(posicao), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
